sudoku_scoreboard: RTL and testbench
====================================

Name: sudoku_scoreboard

Overview:
- Parametrised checker that sits between the puzzle bank and the sudoku solver in the regression harness.
- Sequences puzzle indices to the bank, times each solve, and scores results as correct, wrong, gave-up or timed-out.
- Adds bounded runs (stops after NUM_PUZZLES), a per-puzzle timeout with solver abort, a configurable bank match latency, max-latency tracking, saturating counters and a done flag.
- The tristate puzzle bus stays outside this block; `bank_drive` tells the top level when to drive it.

Parameters:
- NUM_PUZZLES, 256: puzzles per run; must be in 1..2^IDX_W.
- IDX_W, 8: bank index width.
- CNT_W, 10: width of each result counter.
- CYC_W, 32: width of the cycle and latency counters.
- TIMEOUT, 0: per-puzzle cycle limit; 0 disables the timeout.
- MATCH_LAT, 1: cycles from bank index to valid `bank_match`; range 1..4.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  begin or restart a run (pulse)
- solver_oe  in  1  solver is driving the puzzle bus (check phase)
- next_puzzle  in  1  solver consumed the shown puzzle
- solution  in  1  solver result is on the bus
- give_up  in  1  solver abandoned the current puzzle
- solver_abort  out  1  one-cycle pulse: abandon the current puzzle (timeout)
- solver_hold  out  1  no further puzzles available; solver must stall
- bank_index  out  IDX_W  `check_index` when `solver_oe`=1, else `show_index`
- bank_drive  out  1  bank drives the bus (= !`solver_oe`)
- bank_match  in  1  bank compare result, valid MATCH_LAT cycles after the index
- num_correct  out  CNT_W  solutions that matched
- num_wrong  out  CNT_W  solutions that mismatched
- num_gave_up  out  CNT_W  `give_up` results
- num_timeout  out  CNT_W  timeout aborts
- cycles  out  CYC_W  cycles elapsed while working
- max_latency  out  CYC_W  longest `next_puzzle`-to-result interval
- busy  out  1  state is RUN or DRAIN
- done  out  1  all NUM_PUZZLES puzzles scored

Behaviour:
- Reset: all outputs 0; state IDLE; `show_index`, `check_index`, issued count, result count, latency counter, outstanding flag and match pipeline all 0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: `start` -> RUN. Solver inputs are ignored in IDLE.
- RUN, issue side:
  - `next_puzzle` increments `show_index` and the issued count.
  - It sets `outstanding` and clears the latency counter to 0.
  - When the issued count reaches NUM_PUZZLES: go to DRAIN; `solver_hold`=1 in DRAIN and DONE.
- Results (RUN or DRAIN): a result is `solution`, `give_up` or a timeout. Each result:
  - increments `check_index` and the result count;
  - clears `outstanding`;
  - updates `max_latency` = max(`max_latency`, latency counter + 1).
- Solution scoring:
  - `solution` pushes a token into a MATCH_LAT-deep valid shift register.
  - When the token exits, sample `bank_match`: 1 -> `num_correct`++, 0 -> `num_wrong`++.
- `give_up`: `num_gave_up`++ in the same cycle.
- `solution` and `give_up` in the same cycle: treat as `solution` only; this is one result.
- `next_puzzle` with a result in the same cycle: the result closes the old puzzle and the new puzzle opens with latency 0. Net `outstanding` = 1.
- Timeout (TIMEOUT>0):
  - Condition: `outstanding`, latency counter == TIMEOUT-1, and no result this cycle.
  - Action: `solver_abort`=1 for that cycle, `num_timeout`++, treated as a result. Next cycle `outstanding`=0.
  - A result arriving after the abort with `outstanding`=0 is ignored.
- Latency counter: increments each cycle while `outstanding`; saturates.
- `cycles`:
  - Increments every cycle after the first `next_puzzle` or `solution` of the run, until DONE.
  - Frozen in DONE.
- DRAIN -> DONE when the result count == NUM_PUZZLES and the match pipeline is empty. `done`=1 in DONE.
- Counter saturation: all counters stop at all-ones and never wrap.
- `start` in DONE: clear all counters and indices, go to RUN. `start` in RUN or DRAIN is ignored.
- `rst` mid-run: immediate return to reset values; pending match tokens are discarded.
- `bank_index` and `bank_drive` are combinational from `solver_oe` and the index registers.

Decomposition:
- Package `sudoku_scoreboard_pkg`:
  - state enum (IDLE/RUN/DRAIN/DONE);
  - saturating-increment function;
  - default width constants.
- Sub-module `sat_counter` (parameter W; inputs `inc`, `clr`; output `q`) is instantiated for all result counters, `cycles` and the latency counter.

Test Plan:
1. NUM_PUZZLES=4, MATCH_LAT=1; solver solves all four, `bank_match`=1,1,0,1 -> `num_correct`=3, `num_wrong`=1, `done`=1, `solver_hold`=1 after the 4th `next_puzzle`.
2. TIMEOUT=10; solver never answers puzzle 0 -> `solver_abort` pulses 10 cycles after `next_puzzle`, `num_timeout`=1, `check_index`=1, `max_latency`=10.
3. Same-cycle `next_puzzle`+`solution` -> `outstanding` stays 1, latency restarts at 0, `show_index` and `check_index` both increment, one score after MATCH_LAT.
4. `solution`+`give_up` in the same cycle -> only the solution path counts; `num_gave_up` unchanged, result count +1.
5. MATCH_LAT=3; last `solution` arrives -> `done` asserts only after 3 cycles, when the match is scored; `cycles` frozen from then on.
6. CNT_W=2 with 5 wrong answers -> `num_wrong` saturates at 3. `rst` mid-DRAIN -> all outputs 0, state IDLE; a following `start` runs cleanly.

Source files
------------

// File: rtl/sudoku_scoreboard_pkg.sv
// Shared types and helpers for the sudoku solver scoreboard.
// Holds the run-state encoding, default widths and a width-aware saturating increment.
package sudoku_scoreboard_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_PUZZLES = 256;
    localparam int DEF_IDX_W       = 8;
    localparam int DEF_CNT_W       = 10;
    localparam int DEF_CYC_W       = 32;
    localparam int DEF_TIMEOUT     = 0;
    localparam int DEF_MATCH_LAT   = 1;

    // Widest value sat_inc can handle; callers cast down to their own width.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v, input int w);
        logic [SAT_W-1:0] ones;
        ones = (w >= SAT_W) ? '1 : ((SAT_W'(1) << w) - SAT_W'(1));
        return (v == ones) ? v : v + SAT_W'(1);
    endfunction

endpackage

// File: rtl/sudoku_scoreboard_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// Used for the result tallies, the run cycle count and the per-puzzle latency.
module sat_counter
    import sudoku_scoreboard_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc)
            q <= W'(sat_inc(SAT_W'(q), W));
    end

endmodule

// File: rtl/sudoku_scoreboard.sv
// Sequences puzzles from the bank to the solver, times each solve and scores the
// outcome as correct, wrong, gave-up or timed-out; stops after NUM_PUZZLES.
module sudoku_scoreboard
    import sudoku_scoreboard_pkg::*;
#(
    parameter int NUM_PUZZLES = DEF_NUM_PUZZLES,
    parameter int IDX_W       = DEF_IDX_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int CYC_W       = DEF_CYC_W,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int MATCH_LAT   = DEF_MATCH_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             solver_oe,
    input  logic             next_puzzle,
    input  logic             solution,
    input  logic             give_up,
    output logic             solver_abort,
    output logic             solver_hold,
    output logic [IDX_W-1:0] bank_index,
    output logic             bank_drive,
    input  logic             bank_match,
    output logic [CNT_W-1:0] num_correct,
    output logic [CNT_W-1:0] num_wrong,
    output logic [CNT_W-1:0] num_gave_up,
    output logic [CNT_W-1:0] num_timeout,
    output logic [CYC_W-1:0] cycles,
    output logic [CYC_W-1:0] max_latency,
    output logic             busy,
    output logic             done
);

    // Issue/result counts need one bit more than the index to reach 2^IDX_W.
    localparam int               RC_W    = IDX_W + 1;
    localparam logic [RC_W-1:0]  LAST    = RC_W'(NUM_PUZZLES);
    localparam logic [CYC_W-1:0] TO_LAST = (TIMEOUT > 0) ? CYC_W'(TIMEOUT - 1) : '0;
    localparam int               NRES    = 4;

    state_t               state;
    logic [IDX_W-1:0]     show_index;
    logic [IDX_W-1:0]     check_index;
    logic [RC_W-1:0]      issued;
    logic [RC_W-1:0]      issued_nxt;
    logic [RC_W-1:0]      results;
    logic [RC_W-1:0]      results_nxt;
    logic                 outstanding;
    logic                 started;
    logic [MATCH_LAT-1:0] vld_pipe;
    logic [MATCH_LAT-1:0] vld_pipe_nxt;
    logic [CYC_W-1:0]     latency;
    logic [CYC_W-1:0]     lat_plus;

    logic active;
    logic start_acc;
    logic issue;
    logic sol_res;
    logic gu_res;
    logic to_hit;
    logic result;
    logic score;
    logic res_done;

    logic [NRES-1:0]            res_inc;
    logic [NRES-1:0][CNT_W-1:0] res_q;

    always_comb begin
        active       = (state == RUN) || (state == DRAIN);
        start_acc    = start && ((state == IDLE) || (state == DONE));
        issue        = (state == RUN) && next_puzzle;
        // Results only count against an open puzzle; solution shadows give_up.
        sol_res      = active && outstanding && solution;
        gu_res       = active && outstanding && give_up && !solution;
        to_hit       = (TIMEOUT > 0) && active && outstanding && !solution && !give_up
                       && (latency == TO_LAST);
        result       = sol_res || gu_res || to_hit;
        score        = vld_pipe[MATCH_LAT-1];
        vld_pipe_nxt = (vld_pipe << 1) | MATCH_LAT'(sol_res);
        issued_nxt   = issue  ? RC_W'(sat_inc(SAT_W'(issued), RC_W))  : issued;
        results_nxt  = result ? RC_W'(sat_inc(SAT_W'(results), RC_W)) : results;
        // Finish on the edge that scores the last token, not one cycle later.
        res_done     = (results_nxt == LAST) && (vld_pipe_nxt == '0);
        lat_plus     = CYC_W'(sat_inc(SAT_W'(latency), CYC_W));
    end

    assign solver_abort = to_hit;
    assign bank_index   = solver_oe ? check_index : show_index;
    assign bank_drive   = !solver_oe;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            show_index  <= '0;
            check_index <= '0;
            issued      <= '0;
            results     <= '0;
            outstanding <= 1'b0;
            started     <= 1'b0;
            vld_pipe    <= '0;
            max_latency <= '0;
        end else if (start_acc) begin
            show_index  <= '0;
            check_index <= '0;
            issued      <= '0;
            results     <= '0;
            outstanding <= 1'b0;
            started     <= 1'b0;
            vld_pipe    <= '0;
            max_latency <= '0;
        end else begin
            vld_pipe <= vld_pipe_nxt;
            issued   <= issued_nxt;
            results  <= results_nxt;
            if (issue)
                show_index <= IDX_W'(sat_inc(SAT_W'(show_index), IDX_W));
            if (result) begin
                check_index <= IDX_W'(sat_inc(SAT_W'(check_index), IDX_W));
                if (lat_plus > max_latency)
                    max_latency <= lat_plus;
            end
            // A new puzzle opening in the same cycle as a result keeps it open.
            if (issue)
                outstanding <= 1'b1;
            else if (result)
                outstanding <= 1'b0;
            if (active && (next_puzzle || solution))
                started <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            solver_hold <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (issue && (issued_nxt == LAST)) begin
                        state       <= DRAIN;
                        solver_hold <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_done) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start) begin
                        state       <= RUN;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        solver_hold <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign res_inc = {to_hit, gu_res, score && !bank_match, score && bank_match};

    for (genvar i = 0; i < NRES; i++) begin : g_res
        sat_counter #(.W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (res_inc[i]),
            .clr (start_acc),
            .q   (res_q[i])
        );
    end

    assign num_correct = res_q[0];
    assign num_wrong   = res_q[1];
    assign num_gave_up = res_q[2];
    assign num_timeout = res_q[3];

    sat_counter #(.W(CYC_W)) u_cycles (
        .clk (clk),
        .rst (rst),
        .inc (active && started),
        .clr (start_acc),
        .q   (cycles)
    );

    sat_counter #(.W(CYC_W)) u_latency (
        .clk (clk),
        .rst (rst),
        .inc (outstanding),
        .clr (start_acc || issue),
        .q   (latency)
    );

endmodule

// File: tb/tb_sudoku_scoreboard.sv
// Bench for sudoku_scoreboard: a 4-puzzle instance driven from a vector table with a
// score queue, and a 6-puzzle instance (timeout, 3-cycle match, 2-bit counters).
module tb_sudoku_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, solver_oe, next_puzzle, solution, give_up;
    logic bm1, bm2;

    logic        a_abort, a_hold, a_drive, a_busy, a_done;
    logic [7:0]  a_idx;
    logic [9:0]  a_cor, a_wr, a_gu, a_to;
    logic [31:0] a_cyc, a_maxl;

    logic        b_abort, b_hold, b_drive, b_busy, b_done;
    logic [7:0]  b_idx;
    logic [1:0]  b_cor, b_wr, b_gu, b_to;
    logic [31:0] b_cyc, b_maxl;

    sudoku_scoreboard #(.NUM_PUZZLES(4), .IDX_W(8), .CNT_W(10), .CYC_W(32),
                        .TIMEOUT(0), .MATCH_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start(start), .solver_oe(solver_oe),
        .next_puzzle(next_puzzle), .solution(solution), .give_up(give_up),
        .solver_abort(a_abort), .solver_hold(a_hold), .bank_index(a_idx),
        .bank_drive(a_drive), .bank_match(bm1), .num_correct(a_cor),
        .num_wrong(a_wr), .num_gave_up(a_gu), .num_timeout(a_to),
        .cycles(a_cyc), .max_latency(a_maxl), .busy(a_busy), .done(a_done)
    );

    sudoku_scoreboard #(.NUM_PUZZLES(6), .IDX_W(8), .CNT_W(2), .CYC_W(32),
                        .TIMEOUT(10), .MATCH_LAT(3)) u2 (
        .clk(clk), .rst(rst), .start(start), .solver_oe(solver_oe),
        .next_puzzle(next_puzzle), .solution(solution), .give_up(give_up),
        .solver_abort(b_abort), .solver_hold(b_hold), .bank_index(b_idx),
        .bank_drive(b_drive), .bank_match(bm2), .num_correct(b_cor),
        .num_wrong(b_wr), .num_gave_up(b_gu), .num_timeout(b_to),
        .cycles(b_cyc), .max_latency(b_maxl), .busy(b_busy), .done(b_done)
    );

    // Bank model for u1: answer key looked up by the presented index, one cycle later.
    logic       key1 [0:3] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [3:0] dl1 = '0;
    always @(posedge clk) dl1 <= {dl1[2:0], key1[a_idx[1:0]]};
    assign bm1 = dl1[0];
    assign bm2 = 1'b0;

    int   n_vec = 0;
    int   n_err = 0;
    logic sb [$];
    bit   mon_on = 1'b0;
    logic [9:0] pc = '0, pw = '0;
    bit   cyc_on = 1'b0;
    int   cyc_exp = 0;

    typedef struct {
        logic st, oe, np, sol, gu;
        logic busy, hold, done;
        int   cor, wr, gup, idx;
    } vec_t;
    vec_t tv [19];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic st, input logic oe, input logic np,
                        input logic sol, input logic gu);
        logic e;
        @(negedge clk);
        start = st; solver_oe = oe; next_puzzle = np; solution = sol; give_up = gu;
        @(posedge clk);
        #1;
        if (cyc_on) cyc_exp++;
        if (mon_on && (a_cor > pc || a_wr > pw)) begin
            if (sb.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL sb_underflow: got a score, want none pending");
            end else begin
                e = sb.pop_front();
                chk("sb_score", {63'd0, a_cor > pc}, {63'd0, e});
            end
        end
        pc = a_cor;
        pw = a_wr;
    endtask

    initial begin
        int chk_i;
        //           st oe np so gu  bu ho dn  cor wr gup idx
        tv[0]  = '{1, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0};
        tv[1]  = '{0, 0, 1, 0, 0,  1, 0, 0,  0, 0, 0, 1};
        tv[2]  = '{0, 1, 0, 1, 0,  1, 0, 0,  0, 0, 0, 1};
        tv[3]  = '{0, 0, 1, 0, 0,  1, 0, 0,  1, 0, 0, 2};
        tv[4]  = '{0, 1, 0, 1, 0,  1, 0, 0,  1, 0, 0, 2};
        tv[5]  = '{0, 0, 1, 0, 0,  1, 0, 0,  2, 0, 0, 3};
        tv[6]  = '{0, 1, 0, 1, 0,  1, 0, 0,  2, 0, 0, 3};
        tv[7]  = '{0, 0, 1, 0, 0,  1, 1, 0,  2, 1, 0, 4};
        tv[8]  = '{0, 1, 0, 1, 0,  1, 1, 0,  2, 1, 0, 4};
        tv[9]  = '{0, 0, 0, 0, 0,  0, 1, 1,  3, 1, 0, 4};
        tv[10] = '{1, 0, 0, 0, 0,  1, 0, 0,  0, 0, 0, 0};
        tv[11] = '{0, 0, 1, 0, 0,  1, 0, 0,  0, 0, 0, 1};
        tv[12] = '{0, 1, 1, 1, 0,  1, 0, 0,  0, 0, 0, 1};
        tv[13] = '{0, 1, 0, 1, 1,  1, 0, 0,  1, 0, 0, 2};
        tv[14] = '{0, 0, 1, 0, 0,  1, 0, 0,  2, 0, 0, 3};
        tv[15] = '{0, 0, 0, 0, 1,  1, 0, 0,  2, 0, 1, 3};
        tv[16] = '{0, 0, 1, 0, 0,  1, 1, 0,  2, 0, 1, 4};
        tv[17] = '{0, 1, 0, 1, 0,  1, 1, 0,  2, 0, 1, 4};
        tv[18] = '{0, 0, 0, 0, 0,  0, 1, 1,  3, 0, 1, 4};

        rst = 1'b1; start = 1'b0; solver_oe = 1'b0;
        next_puzzle = 1'b0; solution = 1'b0; give_up = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_hold", a_hold, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_cor", a_cor, 0);
        chk("rst_abort", b_abort, 0);
        chk("rst_maxl", b_maxl, 0);
        chk("rst_cyc", b_cyc, 0);
        @(negedge clk);
        rst = 1'b0;

        // Full runs on u1: scored solves, then overlap of next+solution and solution+give_up.
        mon_on = 1'b1;
        chk_i = 0;
        for (int i = 0; i < 19; i++) begin
            if (tv[i].st) chk_i = 0;
            if (tv[i].sol) sb.push_back(key1[chk_i]);
            if (tv[i].sol || tv[i].gu) chk_i++;
            step(tv[i].st, tv[i].oe, tv[i].np, tv[i].sol, tv[i].gu);
            chk($sformatf("v%0d_busy", i), a_busy, tv[i].busy);
            chk($sformatf("v%0d_hold", i), a_hold, tv[i].hold);
            chk($sformatf("v%0d_done", i), a_done, tv[i].done);
            chk($sformatf("v%0d_cor", i), a_cor, tv[i].cor);
            chk($sformatf("v%0d_wr", i), a_wr, tv[i].wr);
            chk($sformatf("v%0d_gu", i), a_gu, tv[i].gup);
            chk($sformatf("v%0d_idx", i), a_idx, tv[i].idx);
            chk($sformatf("v%0d_drive", i), a_drive, !tv[i].oe);
            chk($sformatf("v%0d_abort", i), a_abort, 0);
        end
        chk("sb_empty", sb.size(), 0);
        mon_on = 1'b0;

        // u2: timeout on puzzle 0.
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 0, 0, 0);
        rst = 1'b0;
        step(1, 0, 0, 0, 0);
        chk("t2_busy", b_busy, 1);
        step(0, 0, 1, 0, 0);
        cyc_exp = 0;
        cyc_on = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("t2_abort_k%0d", k), b_abort, (k == 9));
            if (k == 10) begin
                chk("t2_timeout", b_to, 1);
                chk("t2_maxl", b_maxl, 10);
            end
        end
        // Late answer with nothing outstanding must be ignored.
        step(0, 1, 0, 1, 0);
        chk("t2_chk_idx", b_idx, 1);
        repeat (4) step(0, 0, 0, 0, 0);
        chk("t2_late_wr", b_wr, 0);

        // Five wrong answers into a 2-bit counter; last one drives done after 3 cycles.
        for (int p = 1; p <= 5; p++) begin
            step(0, 0, 1, 0, 0);
            if (p == 5) chk("t5_hold", b_hold, 1);
            step(0, 1, 0, 1, 0);
        end
        chk("t5_done_j0", b_done, 0);
        for (int j = 1; j <= 3; j++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("t5_done_j%0d", j), b_done, (j == 3));
        end
        cyc_on = 1'b0;
        chk("t6_wr_sat", b_wr, 3);
        chk("t5_to", b_to, 1);
        chk("t5_cor", b_cor, 0);
        chk("t5_gu", b_gu, 0);
        chk("t5_maxl", b_maxl, 10);
        chk("t5_cyc", b_cyc, cyc_exp);
        repeat (3) step(0, 0, 0, 0, 0);
        chk("t5_cyc_frozen", b_cyc, cyc_exp);
        chk("t5_done_hold", b_done, 1);

        // Restart from DONE, fill to DRAIN with a token in flight, then reset.
        step(1, 0, 0, 0, 0);
        chk("t6_rs_busy", b_busy, 1);
        chk("t6_rs_wr", b_wr, 0);
        chk("t6_rs_cyc", b_cyc, 0);
        repeat (6) step(0, 0, 1, 0, 0);
        chk("t6_drain_hold", b_hold, 1);
        step(0, 1, 0, 1, 0);
        @(negedge clk);
        start = 1'b0; solver_oe = 1'b0; next_puzzle = 1'b0; solution = 1'b0; give_up = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", b_busy, 0);
        chk("t6_rst_hold", b_hold, 0);
        chk("t6_rst_done", b_done, 0);
        chk("t6_rst_idx", b_idx, 0);
        chk("t6_rst_maxl", b_maxl, 0);
        chk("t6_rst_cyc", b_cyc, 0);
        chk("t6_rst_to", b_to, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1, 0, 0, 0, 0);
        chk("t6_run_busy", b_busy, 1);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chk("t6_run_wr_early", b_wr, 0);
        repeat (2) step(0, 0, 0, 0, 0);
        chk("t6_run_wr", b_wr, 1);
        chk("t6_run_hold", b_hold, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
